// File: rtl/accel_output_writer.sv
// Output drain engine: buffers psum words in a small FIFO and writes them to DDR
// over the M00 AXI4-Lite write channels, one AW/W/B exchange per word.
module accel_output_writer #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int OUT_DEPTH            = 32
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              start,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   output_base_addr,
  input  logic [5:0]                        num_words,
  input  logic                              out_storage_wr_en,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   out_storage_wr_data,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              overflow,
  output logic [$clog2(OUT_DEPTH):0]        store_count
);
  localparam int AW = $clog2(OUT_DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR_DATA, RESP, DONE} state_t;

  state_t state_q, state_d;
  logic [C_M00_AXI_DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW:0]                     wptr_q, rptr_q;
  logic [C_M00_AXI_ADDR_WIDTH-1:0] base_q, base_d, awaddr_q, awaddr_d;
  logic [C_M00_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [5:0]                      num_q, num_d, idx_q, idx_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic error_q, error_d, overflow_q, overflow_d;
  logic empty, full, pop, push;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = (state_q == WAIT_DATA) && (num_q != 6'd0) && !empty;
  // a pop in the same cycle frees the slot the push lands in
  assign push  = out_storage_wr_en && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q[AW-1:0]] <= out_storage_wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      base_q     <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    num_d      = num_q;
    idx_d      = idx_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = output_base_addr;
          num_d      = num_words;
          idx_d      = '0;
          error_d    = 1'b0;
          overflow_d = 1'b0;
          state_d    = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (num_q == 6'd0) state_d = DONE;
        else if (pop) begin
          wdata_d   = mem[rptr_q[AW-1:0]];
          awaddr_d  = base_q + (C_M00_AXI_ADDR_WIDTH'(idx_q) << 2);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        // each channel retires independently; leave once both are done
        if (m00_axi_awready) awvalid_d = 1'b0;
        if (m00_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = RESP;
      end
      RESP: begin
        if (m00_axi_bvalid) begin
          if (m00_axi_bresp != 2'b00) error_d = 1'b1;
          idx_d   = idx_q + 6'd1;
          state_d = (idx_d == num_q) ? DONE : WAIT_DATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (out_storage_wr_en && !push) overflow_d = 1'b1;
  end

  assign m00_axi_awaddr  = awaddr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = (state_q == RESP);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign error           = error_q;
  assign overflow        = overflow_q;
  assign store_count     = wptr_q - rptr_q;
endmodule

// File: tb/tb_accel_output_writer.sv
// Randomized bench for accel_output_writer: AXI slave model with configurable
// ready/response behaviour, queue-based store model and per-job write checks.
module tb_accel_output_writer;
  logic        CLK = 1'b0, RESET = 1'b1, start = 1'b0;
  logic [31:0] output_base_addr = '0;
  logic [5:0]  num_words = '0;
  logic        out_storage_wr_en = 1'b0;
  logic [31:0] out_storage_wr_data = '0;
  logic [31:0] m00_axi_awaddr;
  logic [2:0]  m00_axi_awprot;
  logic        m00_axi_awvalid, m00_axi_awready = 1'b0;
  logic [31:0] m00_axi_wdata;
  logic [3:0]  m00_axi_wstrb;
  logic        m00_axi_wvalid, m00_axi_wready = 1'b0;
  logic [1:0]  m00_axi_bresp = 2'b00;
  logic        m00_axi_bvalid = 1'b0, m00_axi_bready;
  logic        busy, done, error, overflow;
  logic [5:0]  store_count;

  accel_output_writer dut (
    .CLK(CLK), .RESET(RESET), .start(start), .output_base_addr(output_base_addr),
    .num_words(num_words), .out_storage_wr_en(out_storage_wr_en),
    .out_storage_wr_data(out_storage_wr_data), .m00_axi_awaddr(m00_axi_awaddr),
    .m00_axi_awprot(m00_axi_awprot), .m00_axi_awvalid(m00_axi_awvalid),
    .m00_axi_awready(m00_axi_awready), .m00_axi_wdata(m00_axi_wdata),
    .m00_axi_wstrb(m00_axi_wstrb), .m00_axi_wvalid(m00_axi_wvalid),
    .m00_axi_wready(m00_axi_wready), .m00_axi_bresp(m00_axi_bresp),
    .m00_axi_bvalid(m00_axi_bvalid), .m00_axi_bready(m00_axi_bready),
    .busy(busy), .done(done), .error(error), .overflow(overflow),
    .store_count(store_count)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0, cyc = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // slave knobs and model state
  bit          rnd = 1'b0;
  int          aw_dly = 0, w_dly = 0, err_abs = -1;
  int          aw_wt = 0, w_wt = 0, cur_ad = 0, cur_wd = 0;
  int          aw_n = 0, w_n = 0, b_n = 0;
  bit          pa, pw, ha, hw;
  logic [31:0] la, lw;
  logic [31:0] aw_obs[$], w_obs[$], mq[$];
  bit          ovf_exp = 1'b0;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // AXI slave: ready after a per-beat delay, one B per completed AW+W pair
  initial forever begin
    @(posedge CLK); #1;
    if (!m00_axi_awvalid) aw_wt = 0;
    if (aw_wt == 0) cur_ad = rnd ? int'($urandom_range(0, 3)) : aw_dly;
    m00_axi_awready = (aw_wt >= cur_ad);
    if (m00_axi_awvalid) aw_wt++;
    if (!m00_axi_wvalid) w_wt = 0;
    if (w_wt == 0) cur_wd = rnd ? int'($urandom_range(0, 3)) : w_dly;
    m00_axi_wready = (w_wt >= cur_wd);
    if (m00_axi_wvalid) w_wt++;
    m00_axi_bvalid = (((aw_n < w_n) ? aw_n : w_n) > b_n) && (!rnd || $urandom_range(0, 1) == 1);
    m00_axi_bresp  = (b_n == err_abs) ? 2'b10 : 2'b00;
  end

  // handshake monitor and channel protocol checks
  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      aw_n = 0; w_n = 0; b_n = 0;
      pa = 0; pw = 0; ha = 0; hw = 0;
      aw_obs.delete(); w_obs.delete();
    end else begin
      if (pa) chk("aw_drop", 64'(m00_axi_awvalid), 64'(0));
      if (pw) chk("w_drop", 64'(m00_axi_wvalid), 64'(0));
      if (ha) begin
        chk("aw_hold", 64'(m00_axi_awvalid), 64'(1));
        chk("aw_stable", 64'(m00_axi_awaddr), 64'(la));
      end
      if (hw) begin
        chk("w_hold", 64'(m00_axi_wvalid), 64'(1));
        chk("w_stable", 64'(m00_axi_wdata), 64'(lw));
      end
      pa = m00_axi_awvalid && m00_axi_awready;
      pw = m00_axi_wvalid && m00_axi_wready;
      ha = m00_axi_awvalid && !m00_axi_awready;
      hw = m00_axi_wvalid && !m00_axi_wready;
      la = m00_axi_awaddr;
      lw = m00_axi_wdata;
      if (pa) begin aw_obs.push_back(m00_axi_awaddr); aw_n++; end
      if (pw) begin w_obs.push_back(m00_axi_wdata); w_n++; end
      if (m00_axi_bvalid && m00_axi_bready) b_n++;
    end
  end

  task automatic chk_rst(input string t);
    chk({t, "_awvalid"}, 64'(m00_axi_awvalid), 64'(0));
    chk({t, "_wvalid"}, 64'(m00_axi_wvalid), 64'(0));
    chk({t, "_bready"}, 64'(m00_axi_bready), 64'(0));
    chk({t, "_awaddr"}, 64'(m00_axi_awaddr), 64'(0));
    chk({t, "_wdata"}, 64'(m00_axi_wdata), 64'(0));
    chk({t, "_awprot"}, 64'(m00_axi_awprot), 64'(0));
    chk({t, "_wstrb"}, 64'(m00_axi_wstrb), 64'(4'hF));
    chk({t, "_busy"}, 64'(busy), 64'(0));
    chk({t, "_done"}, 64'(done), 64'(0));
    chk({t, "_error"}, 64'(error), 64'(0));
    chk({t, "_ovf"}, 64'(overflow), 64'(0));
    chk({t, "_cnt"}, 64'(store_count), 64'(0));
  endtask

  task automatic push_idle(input logic [31:0] d);
    out_storage_wr_en = 1'b1;
    out_storage_wr_data = d;
    if (mq.size() < 32) mq.push_back(d);
    else ovf_exp = 1'b1;
    @(posedge CLK); #1;
    out_storage_wr_en = 1'b0;
  endtask

  // lat: check done cycle; extra: random pushes mid-job; erw: job-relative
  // word given a SLVERR; pp: push in the pop cycle of a full store; ign: stray start
  task automatic run_job(input logic [31:0] base, input int n, input bit lat, input int extra,
                         input int erw, input bit pp, input bit ign);
    int t0, ab, wb, bb, pushed, lat_exp;
    bit got, eerr;
    logic [31:0] ea, d;
    ab = aw_obs.size(); wb = w_obs.size(); bb = b_n;
    err_abs = (erw >= 0) ? bb + erw : -1;
    eerr = (erw >= 0) && (erw < n);
    lat_exp = (n == 0) ? 2 : 1 + 3 * n;
    start = 1'b1; output_base_addr = base; num_words = 6'(n); t0 = cyc;
    ovf_exp = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("busy", 64'(busy), 64'(1));
    chk("err_clr", 64'(error), 64'(0));
    chk("ovf_clr", 64'(overflow), 64'(0));
    got = 0; pushed = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      out_storage_wr_en = 1'b0; start = 1'b0;
      if (done) begin
        got = 1;
        if (lat) chk("done_lat", 64'(cyc - t0), 64'(lat_exp));
      end else begin
        if (pp && c == 0) begin
          out_storage_wr_en = 1'b1; out_storage_wr_data = 32'hC0DE_0001;
          mq.push_back(32'hC0DE_0001);
        end else if (pushed < extra && $urandom_range(0, 1) == 1) begin
          d = $urandom;
          out_storage_wr_en = 1'b1; out_storage_wr_data = d;
          mq.push_back(d); pushed++;
        end
        if (pp && c == 1) begin
          chk("pp_cnt", 64'(store_count), 64'(32));
          chk("pp_ovf", 64'(overflow), 64'(0));
        end
        if (ign && c == 2) begin
          start = 1'b1; output_base_addr = 32'hDEAD_0000; num_words = 6'd5;
        end
        @(posedge CLK); #1;
      end
    end
    out_storage_wr_en = 1'b0; start = 1'b0;
    chk("done_seen", 64'(got), 64'(1));
    @(posedge CLK); #1;
    chk("done_pulse", 64'(done), 64'(0));
    chk("idle", 64'(busy), 64'(0));
    chk("aw_cnt", 64'(aw_obs.size() - ab), 64'(n));
    chk("w_cnt", 64'(w_obs.size() - wb), 64'(n));
    chk("b_cnt", 64'(b_n - bb), 64'(n));
    for (int k = 0; k < n && ab + k < aw_obs.size(); k++) begin
      ea = base + 32'(4 * k);
      chk("awaddr", 64'(aw_obs[ab + k]), 64'(ea));
    end
    for (int k = 0; k < n && wb + k < w_obs.size(); k++) begin
      if (mq.size() != 0) chk("wdata", 64'(w_obs[wb + k]), 64'(mq.pop_front()));
    end
    chk("error", 64'(error), 64'(eerr));
    chk("ovf", 64'(overflow), 64'(ovf_exp));
    chk("store_cnt", 64'(store_count), 64'(mq.size()));
    err_abs = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, erw;
    logic [31:0] base;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk_rst("por");

    for (int i = 0; i < 25; i++) push_idle(32'h100 + 32'(i));
    chk("cnt25", 64'(store_count), 64'(25));
    run_job(32'h4000_0000, 25, 1, 0, -1, 0, 0);

    // staggered handshakes, each direction
    aw_dly = 3;
    push_idle(32'hA0); push_idle(32'hA1);
    run_job(32'h8000_0100, 2, 0, 0, -1, 0, 0);
    aw_dly = 0; w_dly = 3;
    push_idle(32'hB0); push_idle(32'hB1);
    run_job(32'h8000_0200, 2, 0, 0, -1, 0, 0);
    w_dly = 0;

    for (int i = 0; i < 4; i++) push_idle(32'hE0 + 32'(i));
    run_job(32'h0000_1000, 4, 1, 0, 2, 0, 0);

    // zero words also clears the error left by the previous job
    run_job(32'h1234_0000, 0, 1, 0, -1, 0, 0);

    push_idle(32'h51); push_idle(32'h52);
    run_job(32'h5000_0000, 2, 1, 0, -1, 0, 1);

    rnd = 1'b1;
    repeat (6) begin
      n = int'($urandom_range(1, 8));
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      erw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      for (int i = 0; i < n; i++) push_idle($urandom);
      run_job(base, n, 0, int'($urandom_range(0, 5)), erw, 0, 0);
    end
    rnd = 1'b0;

    for (int i = 0; i < 33; i++) push_idle(32'h200 + 32'(i));
    chk("full_cnt", 64'(store_count), 64'(32));
    chk("full_ovf", 64'(overflow), 64'(1));
    run_job(32'h6000_0000, 32, 1, 0, -1, 1, 0);

    // reset while AW is outstanding
    push_idle(32'hABCD);
    start = 1'b1; output_base_addr = 32'h0000_3000; num_words = 6'd1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && !m00_axi_awvalid; c++) begin
      @(posedge CLK); #1;
    end
    chk("mid_awvalid", 64'(m00_axi_awvalid), 64'(1));
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk_rst("mid");
    mq.delete(); ovf_exp = 1'b0;
    push_idle(32'h0000_0055);
    run_job(32'h2000_0000, 1, 1, 0, -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/accel_output_writer.md
# accel_output_writer

Output-side drain engine for the MLP/conv accelerator. It collects 32-bit partial-sum words that the control unit pushes through the psum output mux into a small output store. It then writes them to DDR through the M00 AXI4-Lite master write channels, starting at `output_base_addr`. It is the consumer end of the control unit's `out_storage_wr_en` path and the initiator of the write side of the M00 interface.

## Interface
- `C_M00_AXI_DATA_WIDTH`, 32, data width of the write channel and of each stored word.
- `C_M00_AXI_ADDR_WIDTH`, 32, AXI address width.
- `OUT_DEPTH`, 32, output store depth in words; power of two and at least PE_ROWS*PE_COLS (25).

- `CLK`  in  1  clock; all logic is on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a drain job; sampled only in IDLE.
- `output_base_addr`  in  C_M00_AXI_ADDR_WIDTH  byte address of word 0; sampled on `start`.
- `num_words`  in  6  number of words to write in this job; sampled on `start`.
- `out_storage_wr_en`  in  1  push enable for the output store.
- `out_storage_wr_data`  in  C_M00_AXI_DATA_WIDTH  word to push.
- `m00_axi_awaddr`  out  C_M00_AXI_ADDR_WIDTH  write address.
- `m00_axi_awprot`  out  3  constant 0.
- `m00_axi_awvalid` / `m00_axi_awready`  out / in  1  AW handshake.
- `m00_axi_wdata`  out  C_M00_AXI_DATA_WIDTH  write data.
- `m00_axi_wstrb`  out  C_M00_AXI_DATA_WIDTH/8  constant all ones.
- `m00_axi_wvalid` / `m00_axi_wready`  out / in  1  W handshake.
- `m00_axi_bresp`  in  2  write response.
- `m00_axi_bvalid` / `m00_axi_bready`  in / out  1  B handshake.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the job completes.
- `error`  out  1  sticky flag; set by a nonzero `bresp`; cleared on an accepted `start`.
- `overflow`  out  1  sticky flag; set when a push is dropped; cleared on an accepted `start`.
- `store_count`  out  $clog2(OUT_DEPTH)+1  number of words currently in the store.

## Operation

**Output store**
- The store is a FIFO with read and write pointers one bit wider than the address, so full and empty are distinguished.
- A push is accepted when the store is not full, or when a pop occurs in the same cycle.
- A push that is not accepted is dropped and sets `overflow`.
- The store holds its contents across jobs. It is emptied only by pops or by `RESET`.

**FSM states**
- **IDLE.** On `start`, latch `output_base_addr` and `num_words`, clear the word index, `error` and `overflow`, and go to WAIT_DATA. If the latched `num_words` is 0, go to DONE instead.
- **WAIT_DATA.** When the store is not empty, pop the head word into the `wdata` register. Set `awaddr` = base + 4*index using modulo-2^ADDR_WIDTH arithmetic. Assert `awvalid` and `wvalid` and go to ADDR_DATA. If the store is empty, wait indefinitely.
- **ADDR_DATA.**
  - `awvalid` drops the cycle after the AW handshake; `wvalid` drops the cycle after the W handshake. Either handshake may complete first, or both in the same cycle.
  - `awaddr` and `wdata` stay stable while their valid is high.
  - When both handshakes have completed, go to RESP.
- **RESP.**
  - `bready` = 1.
  - On `bvalid`: if `bresp` != 0, set `error`. Increment the index.
  - If index == `num_words`, go to DONE; otherwise go to WAIT_DATA.
  - Errors do not abort the job; every word is still written.
- **DONE.** `done` = 1 for this one cycle, then go to IDLE.

**Other rules**
- `start` outside IDLE is ignored.
- `num_words` greater than 32 is not supported; behaviour is undefined.

## Timing
- **Reset values.** After `RESET`, all outputs are 0, `m00_axi_wstrb` is all ones, the FSM is in IDLE, and the store is empty. This holds from the cycle after `RESET` is sampled high.
- **Reset mid-transaction.** Valid signals drop immediately. The AXI interconnect is reset by the same reset.
- **Push latency.** A push in cycle t is visible in `store_count` at t+1 and is poppable in WAIT_DATA at t+1.
- **Fast path.** `start` is at cycle t and the store is non-empty. WAIT_DATA is at t+1, `awvalid` and `wvalid` are high at t+2, and RESP is at t+3 if the ready signals are high.
- **Throughput.** With zero-wait slaves, each word takes 3 cycles (WAIT_DATA, ADDR_DATA, RESP). An N-word job therefore asserts `done` at t+1+3N.
- **Simultaneous push and pop.** A push and pop in the same cycle leave `store_count` unchanged, including when the store is full.
- **Pointer wrap.** Pointers wrap modulo 2*OUT_DEPTH; the data index wraps modulo OUT_DEPTH.

## Test plan
- **Basic 25-word job.** Push 25 words 0x100..0x118, then `start` with base 0x4000_0000 and `num_words`=25, using zero-wait ready signals. Expect 25 AW/W pairs at 0x4000_0000..0x4000_0060 carrying data 0x100..0x118 in order. Expect `done` at start+76, `error`=0, and `store_count`=0 afterward.
- **Staggered handshakes.** `awready` is delayed 3 cycles while `wready` is immediate, then the reverse. Expect `wvalid` to drop one cycle after its handshake, `awvalid` to hold until its own handshake, no duplicate beats, and data stable while valid is high.
- **Error response.** `bresp`=2'b10 on word 2 of a 4-word job. Expect all 4 words written, `error`=1 after `done`, and `error` cleared by the next accepted `start`.
- **Overflow and simultaneous push/pop.** Push 33 words with no job running: expect `store_count`=32 and `overflow`=1. Then start a job and push during the WAIT_DATA pop cycle while the store is full: expect `store_count` unchanged and no further overflow.
- **Zero words and ignored start.** `num_words`=0: expect `done` at start+2 and no AXI activity. A second `start` while `busy` is ignored: expect only the original words to be written.
- **Reset mid-job.** Assert `RESET` while `awvalid` is high. Expect all outputs 0 the next cycle, `store_count`=0, and a normal 1-word job afterward.
